sram_port_master: RTL and testbench

- Initiator for one port of the team's dual-port byte-enable SRAM (16-bit data, 1-cycle registered read, no read data on write cycles).
- Converts a valid/ready request stream, single or burst, into per-cycle en/we/byte_en/addr/din port drive.
- Captures returned dout into a 2-entry response buffer and presents it on a valid/ready response stream with backpressure.
- Typical use: a DMA/CPU-side client of port A or B, or a memory fill/clear engine at boot.

---
 rtl/sram_port_master.sv | 180 ++++++++++++++++++
 tb/tb_sram_port_master.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_master.sv
// Request-stream sequencer for one byte-enable SRAM port, with a 2-entry FIFO for read responses.
// Define SRAM_PORT_MASTER_STATS_EN to add the saturating rd_count/wr_count access counters.
module sram_port_master #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int LEN_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_be,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [1:0]            sram_byte_en,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  busy
`ifdef SRAM_PORT_MASTER_STATS_EN
   ,
   output logic [15:0]           rd_count,
   output logic [15:0]           wr_count
`endif
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [1:0]            be_q, be_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            occ_q, occ_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] rbuf_q [2];
   logic [DATA_WIDTH-1:0] rbuf_d [2];

   logic       pop;
   logic       room_ok;
   logic       issue;
   logic       accept;
   logic [2:0] level;

   // The read check must see this cycle's pop to sustain one read per cycle with only two
   // buffer entries, so sram_en is gated in the issue cycle; all other port fields are flops.
   always_comb begin
      pop     = (occ_q != 2'd0) && rsp_ready;
      level   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
      room_ok = level < 3'd2;
      issue   = (state_q == S_BUSY) && !rst && (we_q || room_ok);
      accept  = req_valid && (state_q == S_IDLE) && !rst;
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d    = req_we;
               be_d    = req_we ? req_be : 2'b00;
               addr_d  = req_addr;
               wdata_d = req_we ? req_wdata : '0;
               rem_d   = req_len;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (issue) begin
               addr_d = addr_q + ADDR_WIDTH'(1);
               rem_d  = rem_q - LEN_WIDTH'(1);
               if (rem_q == '0) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      inflight_d = issue && !we_q;
      rbuf_d     = rbuf_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
      if (inflight_q) begin
         rbuf_d[wr_ptr_q] = sram_dout;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         be_q       <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            rbuf_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         be_q       <= be_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rem_q      <= rem_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rbuf_q     <= rbuf_d;
      end
   end

   assign req_ready    = (state_q == S_IDLE) && !rst;
   assign sram_en      = issue;
   assign sram_we      = we_q;
   assign sram_byte_en = be_q;
   assign sram_addr    = addr_q;
   assign sram_din     = wdata_q;
   assign rsp_valid    = occ_q != 2'd0;
   assign rsp_rdata    = rbuf_q[rd_ptr_q];
   assign busy         = (state_q != S_IDLE) || inflight_q || (occ_q != 2'd0);

`ifdef SRAM_PORT_MASTER_STATS_EN
   logic [15:0] rd_count_q, rd_count_d;
   logic [15:0] wr_count_q, wr_count_d;

   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (issue && !we_q && (rd_count_q != 16'hFFFF)) begin
         rd_count_d = rd_count_q + 16'd1;
      end
      if (issue && we_q && (wr_count_q != 16'hFFFF)) begin
         wr_count_d = wr_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count_q <= 16'd0;
         wr_count_q <= 16'd0;
      end else begin
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sram_port_master.sv
// Bench for sram_port_master: SRAM port model, cycle-level behavioural reference, directed + random stimulus.
// Build with SRAM_PORT_MASTER_STATS_EN defined to also exercise the access counters.
module tb_sram_port_master;
   localparam int DW = 16;
   localparam int AW = 5;
   localparam int LW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_be;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_len;
   logic [DW-1:0] req_wdata;
   logic          sram_en;
   logic          sram_we;
   logic [1:0]    sram_byte_en;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din;
   logic [DW-1:0] sram_dout;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          busy;
`ifdef SRAM_PORT_MASTER_STATS_EN
   logic [15:0]   rd_count;
   logic [15:0]   wr_count;
`endif

   always #5 clk = ~clk;

   sram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
      .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
      .sram_en(sram_en), .sram_we(sram_we), .sram_byte_en(sram_byte_en),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .busy(busy)
`ifdef SRAM_PORT_MASTER_STATS_EN
      , .rd_count(rd_count), .wr_count(wr_count)
`endif
   );

   // SRAM port: byte-enable writes, registered read data one cycle after a read.
   logic [DW-1:0] sram_mem [32];
   logic [DW-1:0] sram_dout_q;
   assign sram_dout = sram_dout_q;
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) begin
            if (sram_byte_en[0]) sram_mem[sram_addr][7:0] <= sram_din[7:0];
            if (sram_byte_en[1]) sram_mem[sram_addr][15:8] <= sram_din[15:8];
         end else begin
            sram_dout_q <= sram_mem[sram_addr];
         end
      end
   end

   typedef struct packed {
      logic          we;
      logic [1:0]    be;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
   } acc_t;
   typedef struct packed {
      int            cyc;
      logic [DW-1:0] data;
   } rd_t;

   int            n_checks = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            rsp_mode = 0;
   acc_t          pend[$];
   rd_t           rq[$];
   logic [DW-1:0] ref_mem [32];
   logic [DW-1:0] rsp_log[$];
   int            addr_log[$];
   int            rd_total = 0;
   int            m_rd = 0;
   int            m_wr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: every request expands into its list of accesses; each cycle the head access may issue
   // (writes always, reads only while buffered + in-flight reads, net of this cycle's pop, stay below 2);
   // a read's data becomes presentable two cycles after issue and leaves in FIFO order.
   initial begin : model
      bit   exp_ready, exp_valid, pop, exp_en;
      acc_t na;
      rd_t  nr;
      for (int a = 0; a < 32; a++) ref_mem[a] = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            chk("req_ready_in_reset", {31'd0, req_ready}, 32'd0);
            pend.delete();
            rq.delete();
            m_rd = 0;
            m_wr = 0;
         end else begin
            exp_ready = (pend.size() == 0);
            exp_valid = (rq.size() > 0) && (rq[0].cyc <= cyc - 2);
            pop       = exp_valid && rsp_ready;
            exp_en    = (pend.size() > 0) && (pend[0].we || ((rq.size() - int'(pop)) < 2));
            chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
            chk("busy", {31'd0, busy}, {31'd0, (pend.size() > 0) || (rq.size() > 0)});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
            chk("sram_en", {31'd0, sram_en}, {31'd0, exp_en});
`ifdef SRAM_PORT_MASTER_STATS_EN
            chk("rd_count", {16'd0, rd_count}, (m_rd > 65535) ? 32'd65535 : m_rd);
            chk("wr_count", {16'd0, wr_count}, (m_wr > 65535) ? 32'd65535 : m_wr);
`endif
            if (exp_valid) chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, rq[0].data});
            if (exp_en) begin
               na = pend.pop_front();
               chk("sram_we", {31'd0, sram_we}, {31'd0, na.we});
               chk("sram_byte_en", {30'd0, sram_byte_en}, {30'd0, na.be});
               chk("sram_addr", {27'd0, sram_addr}, {27'd0, na.addr});
               chk("sram_din", {16'd0, sram_din}, {16'd0, na.din});
               addr_log.push_back(int'(sram_addr));
               if (na.we) begin
                  if (na.be[0]) ref_mem[na.addr][7:0] = na.din[7:0];
                  if (na.be[1]) ref_mem[na.addr][15:8] = na.din[15:8];
                  m_wr++;
               end else begin
                  nr.cyc  = cyc;
                  nr.data = ref_mem[na.addr];
                  rq.push_back(nr);
                  rd_total++;
                  m_rd++;
               end
            end
            if (pop) begin
               rsp_log.push_back(rsp_rdata);
               void'(rq.pop_front());
            end
            if (req_valid && exp_ready) begin
               for (int i = 0; i <= int'(req_len); i++) begin
                  na.we   = req_we;
                  na.be   = req_we ? req_be : 2'b00;
                  na.addr = AW'((int'(req_addr) + i) % 32);
                  na.din  = req_we ? req_wdata : '0;
                  pend.push_back(na);
               end
            end
         end
      end
   end

   initial begin : rsp_drv
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic send_req(input logic we, input logic [1:0] be, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input logic [DW-1:0] data, input bit quiet);
      bit done = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_we    = we;
      req_be    = be;
      req_addr  = addr;
      req_len   = len;
      req_wdata = data;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(negedge clk);
         if (req_ready) done = 1;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (!done) begin
         n_checks++;
         n_err++;
         $display("FAIL req_accept: req_ready stayed 0, required 1 within 1000 cycles");
      end else if (!quiet) begin
         $display("req we=%0b be=%b addr=%0d len=%0d wdata=%h", we, be, addr, len, data);
      end
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (pend.size() == 0 && rq.size() == 0 && !busy) ok = 1;
      end
      if (!ok) begin
         n_checks++;
         n_err++;
         $display("FAIL wait_idle: busy=%0b after 3000 cycles, required 0", busy);
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sram_en"}, {31'd0, sram_en}, 32'd0);
      chk({tag, "_sram_we"}, {31'd0, sram_we}, 32'd0);
      chk({tag, "_sram_be"}, {30'd0, sram_byte_en}, 32'd0);
      chk({tag, "_sram_addr"}, {27'd0, sram_addr}, 32'd0);
      chk({tag, "_sram_din"}, {16'd0, sram_din}, 32'd0);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_rdata"}, {16'd0, rsp_rdata}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin : watchdog
      #3000000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int base, abase, rbase, t_en, t_v;
      int exp_wrap[4];
      exp_wrap[0] = 30; exp_wrap[1] = 31; exp_wrap[2] = 0; exp_wrap[3] = 1;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_be = 2'b00;
      req_addr = '0; req_len = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("por");

      send_req(1'b1, 2'b11, 5'd0, 5'd31, 16'h0000, 0);
      wait_idle();

      // Single write then read, latency 2 from read enable to rsp_valid.
      send_req(1'b1, 2'b11, 5'd5, 5'd0, 16'hA55A, 0);
      wait_idle();
      base = rsp_log.size();
      send_req(1'b0, 2'b00, 5'd5, 5'd0, 16'h0000, 0);
      t_en = -1; t_v = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (sram_en && !sram_we && t_en < 0) t_en = i;
         if (rsp_valid && t_v < 0) t_v = i;
      end
      chk("rd_latency", t_v - t_en, 2);
      wait_idle();
      chk("single_rsp_count", rsp_log.size() - base, 1);
      if (rsp_log.size() > base) chk("single_rsp_data", {16'd0, rsp_log[base]}, 32'h0000A55A);

      // Partial byte enable merge.
      send_req(1'b1, 2'b11, 5'd5, 5'd0, 16'h1234, 0);
      send_req(1'b1, 2'b10, 5'd5, 5'd0, 16'hABCD, 0);
      base = rsp_log.size();
      send_req(1'b0, 2'b00, 5'd5, 5'd0, 16'h0000, 0);
      wait_idle();
      chk("be_rsp_count", rsp_log.size() - base, 1);
      if (rsp_log.size() > base) chk("be_merge", {16'd0, rsp_log[base]}, 32'h0000AB34);

      // Burst fill and read across the address wrap.
      abase = addr_log.size();
      send_req(1'b1, 2'b11, 5'd30, 5'd3, 16'h00FF, 0);
      wait_idle();
      base = rsp_log.size();
      send_req(1'b0, 2'b00, 5'd30, 5'd3, 16'h0000, 0);
      wait_idle();
      chk("wrap_issue_count", addr_log.size() - abase, 8);
      for (int i = 0; i < 8 && abase + i < addr_log.size(); i++)
         chk("wrap_addr", addr_log[abase + i], exp_wrap[i % 4]);
      chk("wrap_rsp_count", rsp_log.size() - base, 4);
      for (int i = 0; i < 4 && base + i < rsp_log.size(); i++)
         chk("wrap_rsp_data", {16'd0, rsp_log[base + i]}, 32'h000000FF);
      chk("wrap_busy_after", {31'd0, busy}, 32'd0);

      // Backpressure: two reads issue, then the port stalls until responses drain.
      for (int i = 0; i < 8; i++) send_req(1'b1, 2'b11, AW'(8 + i), 5'd0, DW'(16'h1000 + i), 0);
      wait_idle();
      rsp_mode = 1;
      @(posedge clk);
      base  = rsp_log.size();
      rbase = rd_total;
      send_req(1'b0, 2'b00, 5'd8, 5'd7, 16'h0000, 0);
      repeat (10) @(negedge clk);
      chk("bp_reads_issued", rd_total - rbase, 2);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_sram_en", {31'd0, sram_en}, 32'd0);
      rsp_mode = 0;
      wait_idle();
      chk("bp_rsp_count", rsp_log.size() - base, 8);
      for (int i = 0; i < 8 && base + i < rsp_log.size(); i++)
         chk("bp_rsp_data", {16'd0, rsp_log[base + i]}, 32'h1000 + i);

      // Reset during the third cycle of a read burst.
      send_req(1'b0, 2'b00, 5'd8, 5'd7, 16'h0000, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midrst");
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      base = rsp_log.size();
      send_req(1'b0, 2'b00, 5'd5, 5'd0, 16'h0000, 0);
      wait_idle();
      chk("midrst_fresh_count", rsp_log.size() - base, 1);
      if (rsp_log.size() > base) chk("midrst_fresh_data", {16'd0, rsp_log[base]}, 32'h0000AB34);

      // Randomized traffic with random response backpressure, checked by the model every cycle.
      rsp_mode = 2;
      for (int n = 0; n < 300; n++) begin
         logic [LW-1:0] len;
         len = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(0, 31)) : LW'($urandom_range(0, 3));
         send_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), AW'($urandom_range(0, 31)),
                  len, DW'($urandom), 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      rsp_mode = 0;
      wait_idle();

`ifdef SRAM_PORT_MASTER_STATS_EN
      // Drive the write counter past saturation with zero-byte-enable fills.
      for (int n = 0; n < 2049; n++) send_req(1'b1, 2'b00, 5'd0, 5'd31, 16'h0000, 1);
      wait_idle();
      chk("wr_count_saturated", {16'd0, wr_count}, 32'h0000FFFF);
      base = rsp_log.size();
      send_req(1'b0, 2'b00, 5'd5, 5'd0, 16'h0000, 0);
      wait_idle();
      if (rsp_log.size() > base) chk("be00_no_modify", {16'd0, rsp_log[base]}, {16'd0, ref_mem[5]});
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
